// File: rtl/riscv_soft_fetch_pkg.sv
// Shared definitions for the soft RISC-V fetch front end: next-PC source
// encodings, the NOP word and the default reset PC.
package riscv_soft_fetch_pkg;

  localparam int unsigned XPR_LEN_DEF  = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0200;
  localparam logic [31:0] NOP_INST     = 32'h0000_0013;

  typedef enum logic [1:0] {
    PC_PLUS_4 = 2'd0,
    PC_BRANCH = 2'd1,
    PC_JUMP   = 2'd2
  } pc_src_e;

endpackage

// File: rtl/riscv_soft_fetch_queue.sv
// Small synchronous FIFO of {PC, instruction} entries feeding EX; flush wins
// over push/pop in the same cycle.
module riscv_soft_fetch_queue #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 2,
  parameter logic [WIDTH-1:0] RESET_ENTRY = '0,
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] push_data,
  output logic [CW-1:0]    count,
  output logic [WIDTH-1:0] head
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= RESET_ENTRY;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head = mem[rd_ptr];

  a_no_overflow: assert property (@(posedge clk) disable iff (reset || flush)
    !(push && !pop && count == CW'(DEPTH)));
  a_no_underflow: assert property (@(posedge clk) disable iff (reset || flush)
    !(pop && count == '0));

endmodule

// File: rtl/riscv_soft_fetch.sv
// PIF/IF fetch front end: next-PC selection, credit-limited pipelined I-cache
// requests, wrong-path response dropping and an instruction queue toward EX.
module riscv_soft_fetch
  import riscv_soft_fetch_pkg::*;
#(
  parameter int unsigned XPR_LEN = XPR_LEN_DEF,
  parameter logic [XPR_LEN-1:0] RESET_PC = XPR_LEN'(RESET_PC_DEF),
  parameter int unsigned IQ_DEPTH = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         next_PC_src_PIF,
  input  logic               branch_taken_EX,
  input  logic [XPR_LEN-1:0] branch_target_EX,
  input  logic [XPR_LEN-1:0] jump_target_EX,
  input  logic               stall_IF,
  output logic               i_cache_req_valid,
  input  logic               i_cache_req_ready,
  output logic [XPR_LEN-1:0] i_cache_req_addr,
  input  logic               i_cache_resp_valid,
  input  logic [31:0]        i_cache_resp_data,
  output logic               inst_valid_EX,
  output logic [31:0]        instruction_EX,
  output logic [XPR_LEN-1:0] PC_EX
);

  localparam int unsigned CW = $clog2(IQ_DEPTH + 1);
  localparam int unsigned SW = CW + 1;
  localparam int unsigned EW = XPR_LEN + 32;

  logic [XPR_LEN-1:0] fetch_pc;
  logic [XPR_LEN-1:0] resp_pc;
  logic [XPR_LEN-1:0] target;
  logic [CW-1:0]      outstanding;
  logic [CW-1:0]      drop_cnt;
  logic [CW-1:0]      iq_count;
  logic [EW-1:0]      head;
  logic               redirect;
  logic               req_fire;
  logic               push;
  logic               pop;

  // Redirect decision and word-aligned target from the instruction in EX.
  always_comb begin
    redirect = inst_valid_EX && !stall_IF &&
               (next_PC_src_PIF == PC_JUMP ||
                (next_PC_src_PIF == PC_BRANCH && branch_taken_EX));
    if (next_PC_src_PIF == PC_JUMP) target = {jump_target_EX[XPR_LEN-1:2], 2'b00};
    else                            target = {branch_target_EX[XPR_LEN-1:2], 2'b00};
  end

  // Credits cover both in-flight requests and queued entries, so responses
  // can always be absorbed without backpressure.
  assign i_cache_req_valid = !reset &&
                             ((SW'(outstanding) + SW'(iq_count)) < SW'(IQ_DEPTH));
  assign i_cache_req_addr  = redirect ? target : fetch_pc;
  assign req_fire          = i_cache_req_valid && i_cache_req_ready;
  assign push              = i_cache_resp_valid && !redirect && (drop_cnt == '0);
  assign pop               = inst_valid_EX && !stall_IF;

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      if (req_fire)      fetch_pc <= i_cache_req_addr + XPR_LEN'(4);
      else if (redirect) fetch_pc <= target;
      outstanding <= outstanding + CW'(req_fire) - CW'(i_cache_resp_valid);
      // Everything in flight before the redirect is wrong-path.
      if (redirect) begin
        drop_cnt <= outstanding - CW'(i_cache_resp_valid);
        resp_pc  <= target;
      end else if (i_cache_resp_valid) begin
        if (drop_cnt != '0) drop_cnt <= drop_cnt - CW'(1);
        else                resp_pc  <= resp_pc + XPR_LEN'(4);
      end
    end
  end

  riscv_soft_fetch_queue #(
    .WIDTH       (EW),
    .DEPTH       (IQ_DEPTH),
    .RESET_ENTRY ({RESET_PC, NOP_INST})
  ) u_iq (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .flush     (redirect),
    .push_data ({resp_pc, i_cache_resp_data}),
    .count     (iq_count),
    .head      (head)
  );

  assign inst_valid_EX  = (iq_count != '0);
  assign instruction_EX = inst_valid_EX ? head[31:0] : NOP_INST;
  assign PC_EX          = head[EW-1 -: XPR_LEN];

  a_outstanding_cap: assert property (@(posedge clk) disable iff (reset)
    outstanding <= CW'(IQ_DEPTH));
  a_drop_le_outstanding: assert property (@(posedge clk) disable iff (reset)
    drop_cnt <= outstanding);
  a_no_spurious_resp: assert property (@(posedge clk) disable iff (reset)
    i_cache_resp_valid |-> (outstanding != '0));

endmodule
